// File: rtl/width_16to24.sv
`default_nettype none
// ============================================================================
// Module   : width_16to24
// Purpose  : Repacks a stream of 16-bit words into 24-bit words, MSB first.
//            Every three accepted input words produce two output words. Idle
//            cycles between input words do not change how the words are
//            packed. The input and output both use a one-cycle valid pulse.
//            There is no backpressure.
// Ports    : clk        - clock, all logic on the rising edge
//            rst        - synchronous active-high reset
//            flush_in   - push out a partial residue, zero-padded
//                         (exists only when WIDTH_16TO24_FLUSH_EN is defined)
//            valid_in   - data_in is valid this cycle
//            data_in    - 16-bit input word, first byte in [15:8]
//            valid_out  - registered one-cycle pulse per output word
//            data_out   - registered 24-bit output word, first byte in [23:16]
// Options  : WIDTH_16TO24_FLUSH_EN - when defined, adds flush_in and the
//            logic that flushes the residue
// Revision : 1.0 - initial release
// ============================================================================
module width_16to24 (
    input  logic        clk,
    input  logic        rst,
`ifdef WIDTH_16TO24_FLUSH_EN
    input  logic        flush_in,
`endif
    input  logic        valid_in,
    input  logic [15:0] data_in,
    output logic        valid_out,
    output logic [23:0] data_out
);

    // Residue occupancy. The state name gives the number of residue bits
    // that are held and not yet emitted.
    localparam logic [1:0] c_S0  = 2'd0;
    localparam logic [1:0] c_S16 = 2'd1;
    localparam logic [1:0] c_S8  = 2'd2;

    logic [1:0]  r_state_q;
    logic [1:0]  w_state_d;
    logic [15:0] r_res_q;
    logic [15:0] w_res_d;
    logic        r_valid_out_q;
    logic        w_valid_out_d;
    logic [23:0] r_data_out_q;
    logic [23:0] w_data_out_d;

    // A flush is honoured only on an idle input cycle. If a word arrives in
    // the same cycle, the word takes priority and the flush is dropped.
    logic        w_flush_req;

`ifdef WIDTH_16TO24_FLUSH_EN
    assign w_flush_req = flush_in & ~valid_in;
`else
    assign w_flush_req = 1'b0;
`endif

    always_comb begin
        w_state_d     = r_state_q;
        w_res_d       = r_res_q;
        w_valid_out_d = 1'b0;
        w_data_out_d  = r_data_out_q;

        if (valid_in) begin
            case (r_state_q)
                c_S0: begin
                    w_res_d   = data_in;
                    w_state_d = c_S16;
                end
                c_S16: begin
                    w_data_out_d  = {r_res_q, data_in[15:8]};
                    w_valid_out_d = 1'b1;
                    // Only the low byte is still owed. res[15:8] is left
                    // unchanged and is never read in S8.
                    w_res_d[7:0]  = data_in[7:0];
                    w_state_d     = c_S8;
                end
                c_S8: begin
                    w_data_out_d  = {r_res_q[7:0], data_in};
                    w_valid_out_d = 1'b1;
                    w_state_d     = c_S0;
                end
                default: begin
                    // Unreachable encoding. Recover to an empty residue.
                    w_state_d = c_S0;
                end
            endcase
        end else if (w_flush_req) begin
            case (r_state_q)
                c_S16: begin
                    w_data_out_d  = {r_res_q, 8'h00};
                    w_valid_out_d = 1'b1;
                    w_state_d     = c_S0;
                end
                c_S8: begin
                    w_data_out_d  = {r_res_q[7:0], 16'h0000};
                    w_valid_out_d = 1'b1;
                    w_state_d     = c_S0;
                end
                default: begin
                    // Nothing is held, so a flush produces no output.
                    w_state_d = c_S0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_S0;
            r_res_q       <= 16'h0000;
            r_valid_out_q <= 1'b0;
            r_data_out_q  <= 24'h000000;
        end else begin
            r_state_q     <= w_state_d;
            r_res_q       <= w_res_d;
            r_valid_out_q <= w_valid_out_d;
            r_data_out_q  <= w_data_out_d;
        end
    end

    assign valid_out = r_valid_out_q;
    assign data_out  = r_data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_width_16to24.sv
`default_nettype none
// ============================================================================
// Module   : tb_width_16to24
// Purpose  : Directed self-checking bench for width_16to24. It also covers
//            the flush cases when WIDTH_16TO24_FLUSH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_width_16to24;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [15:0] data_in;
    logic        valid_out;
    logic [23:0] data_out;
`ifdef WIDTH_16TO24_FLUSH_EN
    logic        flush_in;
`endif

    int n_checks;
    int n_fail;

    width_16to24 u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef WIDTH_16TO24_FLUSH_EN
        .flush_in  (flush_in),
`endif
        .valid_in  (valid_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the inputs and cross one rising edge. The outputs are sampled
    // 1 ns after that edge.
    task automatic step(input logic v, input logic [15:0] d, input logic f);
        valid_in = v;
        data_in  = d;
`ifdef WIDTH_16TO24_FLUSH_EN
        flush_in = f;
`else
        if (f) $display("note: flush step ignored in this build");
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [23:0] d);
        check({tag, ".valid"}, {23'd0, valid_out}, {23'd0, v});
        check({tag, ".data"}, data_out, d);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = 16'h0000;
`ifdef WIDTH_16TO24_FLUSH_EN
        flush_in = 1'b0;
`endif

        // Reset held for 3 cycles while valid_in toggles.
        step(1'b1, 16'hFFFF, 1'b0); expect_out("rst0", 1'b0, 24'h000000);
        step(1'b0, 16'hFFFF, 1'b0); expect_out("rst1", 1'b0, 24'h000000);
        step(1'b1, 16'h1234, 1'b0); expect_out("rst2", 1'b0, 24'h000000);
        rst = 1'b0;

        // Back-to-back words.
        step(1'b1, 16'h1122, 1'b0); expect_out("b2b_w1", 1'b0, 24'h000000);
        step(1'b1, 16'h3344, 1'b0); expect_out("b2b_w2", 1'b1, 24'h112233);
        step(1'b1, 16'h5566, 1'b0); expect_out("b2b_w3", 1'b1, 24'h445566);
        step(1'b0, 16'h0000, 1'b0); expect_out("b2b_idle", 1'b0, 24'h445566);
        step(1'b0, 16'h0000, 1'b0); expect_out("b2b_hold", 1'b0, 24'h445566);

        // Same words with 4 idle cycles between them.
        step(1'b1, 16'h1122, 1'b0); expect_out("gap_w1", 1'b0, 24'h445566);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'hDEAD, 1'b0); expect_out("gap_idle1", 1'b0, 24'h445566);
        end
        step(1'b1, 16'h3344, 1'b0); expect_out("gap_w2", 1'b1, 24'h112233);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'hBEEF, 1'b0); expect_out("gap_idle2", 1'b0, 24'h112233);
        end
        step(1'b1, 16'h5566, 1'b0); expect_out("gap_w3", 1'b1, 24'h445566);
        step(1'b0, 16'h0000, 1'b0); expect_out("gap_end", 1'b0, 24'h445566);

        // Reset with an 8-bit residue held. The BB byte must never appear.
        step(1'b1, 16'hAAAA, 1'b0); expect_out("mid_w1", 1'b0, 24'h445566);
        step(1'b1, 16'hBBBB, 1'b0); expect_out("mid_w2", 1'b1, 24'hAAAABB);
        rst = 1'b1;
        step(1'b0, 16'h0000, 1'b0); expect_out("mid_rst", 1'b0, 24'h000000);
        rst = 1'b0;
        step(1'b1, 16'h0102, 1'b0); expect_out("mid_p1", 1'b0, 24'h000000);
        step(1'b1, 16'h0304, 1'b0); expect_out("mid_p2", 1'b1, 24'h010203);
        step(1'b1, 16'h0506, 1'b0); expect_out("mid_p3", 1'b1, 24'h040506);
        step(1'b0, 16'h0000, 1'b0); expect_out("mid_end", 1'b0, 24'h040506);

`ifdef WIDTH_16TO24_FLUSH_EN
        // Flush from S16.
        step(1'b1, 16'hDEAD, 1'b0); expect_out("fl16_w", 1'b0, 24'h040506);
        step(1'b0, 16'h0000, 1'b1); expect_out("fl16", 1'b1, 24'hDEAD00);
        // Flush from S8.
        step(1'b1, 16'h1234, 1'b0); expect_out("fl8_w1", 1'b0, 24'hDEAD00);
        step(1'b1, 16'h5678, 1'b0); expect_out("fl8_w2", 1'b1, 24'h123456);
        step(1'b0, 16'h0000, 1'b1); expect_out("fl8", 1'b1, 24'h780000);
        // Flush in S0 produces no pulse.
        step(1'b0, 16'h0000, 1'b1); expect_out("fl0", 1'b0, 24'h780000);
        // Flush together with valid_in: the word wins.
        step(1'b1, 16'hCAFE, 1'b0); expect_out("col_w1", 1'b0, 24'h780000);
        step(1'b1, 16'hBEEF, 1'b1); expect_out("col", 1'b1, 24'hCAFEBE);
        step(1'b0, 16'h0000, 1'b0); expect_out("col_idle", 1'b0, 24'hCAFEBE);
        step(1'b1, 16'h1357, 1'b0); expect_out("col_s8", 1'b1, 24'hEF1357);
        // Reset overrides flush.
        step(1'b1, 16'h9999, 1'b0); expect_out("rfl_w", 1'b0, 24'hEF1357);
        rst = 1'b1;
        step(1'b0, 16'h0000, 1'b1); expect_out("rfl", 1'b0, 24'h000000);
        rst = 1'b0;
        step(1'b0, 16'h0000, 1'b1); expect_out("rfl_after", 1'b0, 24'h000000);
        step(1'b0, 16'h0000, 1'b0);
`else
        // Without flush, a residue is held through idle cycles.
        step(1'b1, 16'hDEAD, 1'b0); expect_out("hold_w1", 1'b0, 24'h040506);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'h0000, 1'b0); expect_out("hold_idle", 1'b0, 24'h040506);
        end
        step(1'b1, 16'hBEEF, 1'b0); expect_out("hold_w2", 1'b1, 24'hDEADBE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
